dbgu32_cmd: RTL and testbench
=============================

// Module: dbgu32_cmd
// PURPOSE
//  Command decoder of the 32-bit debug unit (dbgu32). Consumes bytes from the UART receiver,
//  assembles commands, drives the SoC debug memory port (dbg_mem_op/adr/do/wren) and the CPU
//  reset hold, and returns read words to the UART transmitter. Sits between uart_rx/uart_tx
//  and the SoC memory arbiter; the CPU clock keeps running while memory commands execute.
// PARAMETERS
//  TIMEOUT  20000  clk cycles of silence inside a partial command before the parser aborts to IDLE
//  ADR_INC  4      pointer post-increment after every WRITE/READ (0 = no increment)
// PORTS
//  clk          in   1   system clock
//  n_reset      in   1   asynchronous, active-low reset
//  rx_data      in   8   received byte
//  rx_valid     in   1   1-cycle strobe, rx_data valid
//  tx_data      out  8   byte to transmit
//  tx_start     out  1   1-cycle strobe, load tx_data into transmitter
//  tx_busy      in   1   transmitter busy; tx_start only issued while low
//  dbg_mem_op   out  1   memory request, held until dbg_mem_ack
//  dbg_wren     out  4   byte write enables (4'hF on WRITE, 4'h0 on READ)
//  dbg_adr      out  32  memory address (address pointer)
//  dbg_do       out  32  write data
//  dbg_di       in   32  read data, valid in the dbg_mem_ack cycle
//  dbg_mem_ack  in   1   1-cycle completion strobe from memory arbiter
//  cpu_n_reset  out  1   CPU reset hold, active low
// BEHAVIOUR
//  Reset values: all outputs 0 except cpu_n_reset=1; pointer=0, state IDLE, counters 0.
//  Commands (first byte; arguments little-endian):
//   0x01 SET_ADDR +4 bytes -> pointer = {b4,b3,b2,b1}
//   0x02 CPU_HALT          -> cpu_n_reset=0 (next cycle after strobe)
//   0x03 CPU_RUN           -> cpu_n_reset=1
//   0x04 WRITE +4 bytes    -> mem[pointer] = {b4,b3,b2,b1}, wren=4'hF
//   0x05 READ              -> tx 4 bytes of mem[pointer], LSB first
//   other                  -> ignored, stay IDLE
//  States: IDLE -> ARG (count 4 bytes) -> EXEC -> IDLE for 0x01/0x04; IDLE -> MEM -> TX -> IDLE
//   for 0x05. MEM: dbg_mem_op=1 from cycle after last byte strobe until dbg_mem_ack (inclusive);
//   dbg_adr/dbg_do/dbg_wren stable throughout. READ latches dbg_di on ack.
//  TX: for i=0..3, wait tx_busy==0, pulse tx_start 1 cycle with byte i, wait one cycle for
//   tx_busy to rise before testing it again.
//  Pointer += ADR_INC (mod 2^32, wraps 0xFFFFFFFC->0) in the ack cycle of WRITE/READ.
//  Timeout: counter cleared on every rx_valid; in ARG, reaching TIMEOUT -> IDLE, partial bytes
//   discarded, pointer/memory untouched. Not active in IDLE/MEM/TX.
//  rx_valid while in MEM or TX: byte dropped (no queueing).
//  dbg_mem_ack outside MEM: ignored. 0x02/0x03 do not disturb pointer.
//  n_reset low mid-command: immediate return to reset values, including any dbg_mem_op in flight.
// TESTING
//  01 20 00 00 00, 04 DD CC BB AA -> one mem_op, adr=0x00000020, do=0xAABBCCDD, wren=F; pointer=0x24
//  01 20 00 00 00, 05 with dbg_di=0xAABBCCDD -> tx bytes DD,CC,BB,AA in order, each only when !tx_busy
//  01 20 00 (then TIMEOUT+1 idle cycles), 05 -> READ at adr 0 (partial SET_ADDR discarded)
//  02 -> cpu_n_reset=0; 04 11 22 33 44 -> write 0x44332211 while halted; 03 -> cpu_n_reset=1
//  01 FC FF FF FF, 04 x4, 04 x4 -> writes at 0xFFFFFFFC then 0x00000000; unknown 0x7E -> no activity
//  assert n_reset during held dbg_mem_op (ack withheld) -> mem_op=0, pointer=0, state IDLE next cycle

Source files
------------

// File: rtl/dbgu32_cmd_if.sv
// Byte-stream, transmitter and debug-memory signals of the dbgu32 command decoder.
interface dbgu32_cmd_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        dbg_mem_op;
  logic [3:0]  dbg_wren;
  logic [31:0] dbg_adr;
  logic [31:0] dbg_do;
  logic [31:0] dbg_di;
  logic        dbg_mem_ack;
  logic        cpu_n_reset;

  // Decoder side: consumes rx bytes and memory responses, drives tx and memory requests.
  modport master (
    input  rx_data, rx_valid, tx_busy, dbg_di, dbg_mem_ack,
    output tx_data, tx_start, dbg_mem_op, dbg_wren, dbg_adr, dbg_do, cpu_n_reset
  );

  // Environment side: UART and memory arbiter.
  modport slave (
    output rx_data, rx_valid, tx_busy, dbg_di, dbg_mem_ack,
    input  tx_data, tx_start, dbg_mem_op, dbg_wren, dbg_adr, dbg_do, cpu_n_reset
  );
endinterface

// File: rtl/dbgu32_cmd.sv
// dbgu32 command decoder: assembles UART bytes into debug commands, drives the
// debug memory port and CPU reset hold, and returns read words LSB first.
module dbgu32_cmd #(
  parameter int TIMEOUT = 20000,
  parameter int ADR_INC = 4
) (
  input logic          clk,
  input logic          n_reset,
  dbgu32_cmd_if.master bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARG, S_EXEC, S_MEM, S_TX} state_t;

  state_t      state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic [31:0] arg_q, arg_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0] ptr_q, ptr_d;
  logic [31:0] rd_q, rd_d;
  logic [1:0]  idx_q, idx_d;
  logic        txw_q, txw_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        mem_op_q, mem_op_d;
  logic [3:0]  wren_q, wren_d;
  logic [31:0] dout_q, dout_d;
  logic        cpu_n_reset_q, cpu_n_reset_d;
  logic [31:0] arg_shift;

  // Arguments arrive LSB first, so each new byte enters at the top.
  assign arg_shift = {bus.rx_data, arg_q[31:8]};

  // Next-state and output decode for the command parser.
  always_comb begin
    state_d       = state_q;
    is_wr_d       = is_wr_q;
    arg_d         = arg_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    ptr_d         = ptr_q;
    rd_d          = rd_q;
    idx_d         = idx_q;
    txw_d         = txw_q;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    mem_op_d      = mem_op_q;
    wren_d        = wren_q;
    dout_d        = dout_q;
    cpu_n_reset_d = cpu_n_reset_q;
    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (bus.rx_valid) begin
          case (bus.rx_data)
            8'h01: begin state_d = S_ARG; is_wr_d = 1'b0; cnt_d = 2'd0; end
            8'h02: cpu_n_reset_d = 1'b0;
            8'h03: cpu_n_reset_d = 1'b1;
            8'h04: begin state_d = S_ARG; is_wr_d = 1'b1; cnt_d = 2'd0; end
            8'h05: begin state_d = S_MEM; mem_op_d = 1'b1; wren_d = 4'h0; end
            default: ;
          endcase
        end
      end
      S_ARG: begin
        if (bus.rx_valid) begin
          arg_d = arg_shift;
          cnt_d = cnt_q + 2'd1;
          tmo_d = '0;
          if (cnt_q == 2'd3) begin
            state_d = S_EXEC;
            if (is_wr_q) begin
              mem_op_d = 1'b1;
              wren_d   = 4'hF;
              dout_d   = arg_shift;
            end
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // Silence inside a partial command: drop it without side effects.
          state_d = S_IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_EXEC: begin
        if (!is_wr_q) begin
          ptr_d   = arg_q;
          state_d = S_IDLE;
        end else if (bus.dbg_mem_ack) begin
          mem_op_d = 1'b0;
          wren_d   = 4'h0;
          ptr_d    = ptr_q + 32'(ADR_INC);
          state_d  = S_IDLE;
        end
      end
      S_MEM: begin
        if (bus.dbg_mem_ack) begin
          rd_d     = bus.dbg_di;
          mem_op_d = 1'b0;
          ptr_d    = ptr_q + 32'(ADR_INC);
          idx_d    = 2'd0;
          txw_d    = 1'b0;
          state_d  = S_TX;
        end
      end
      S_TX: begin
        // After each start pulse skip one cycle so tx_busy has time to rise.
        if (txw_q) begin
          txw_d = 1'b0;
        end else if (!bus.tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = rd_q[{idx_q, 3'b000} +: 8];
          txw_d      = 1'b1;
          idx_d      = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any request in flight.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= S_IDLE;
      is_wr_q       <= 1'b0;
      arg_q         <= '0;
      cnt_q         <= '0;
      tmo_q         <= '0;
      ptr_q         <= '0;
      rd_q          <= '0;
      idx_q         <= '0;
      txw_q         <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      mem_op_q      <= 1'b0;
      wren_q        <= '0;
      dout_q        <= '0;
      cpu_n_reset_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      is_wr_q       <= is_wr_d;
      arg_q         <= arg_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      ptr_q         <= ptr_d;
      rd_q          <= rd_d;
      idx_q         <= idx_d;
      txw_q         <= txw_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      mem_op_q      <= mem_op_d;
      wren_q        <= wren_d;
      dout_q        <= dout_d;
      cpu_n_reset_q <= cpu_n_reset_d;
    end
  end

  assign bus.tx_data     = tx_data_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.dbg_mem_op  = mem_op_q;
  assign bus.dbg_wren    = wren_q;
  assign bus.dbg_adr     = ptr_q;
  assign bus.dbg_do      = dout_q;
  assign bus.cpu_n_reset = cpu_n_reset_q;
endmodule

// File: tb/tb_dbgu32_cmd.sv
// Bench for dbgu32_cmd: memory and transmitter responders feed observed-event
// queues; each test pushes expected events and compares them inline.
module tb_dbgu32_cmd;
  localparam int TMO = 64;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  wren;
  } mem_t;

  logic clk;
  logic n_reset;
  dbgu32_cmd_if bus();

  dbgu32_cmd #(.TIMEOUT(TMO), .ADR_INC(4)) dut (
    .clk(clk), .n_reset(n_reset), .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int mem_lat = 1;
  int tx_len = 3;
  bit ack_hold = 1'b0;
  int stray_req = 0;
  int unstable = 0;
  int tx_viol = 0;
  logic [31:0] rd_word = 32'h0;
  mem_t exp_mem[$];
  mem_t obs_mem[$];
  logic [7:0] exp_tx[$];
  logic [7:0] obs_tx[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory arbiter model: acks after mem_lat cycles, checks request stability.
  initial begin : mem_resp
    mem_t cap;
    bit active;
    int w;
    int stray_done;
    bus.dbg_mem_ack = 1'b0;
    bus.dbg_di = 32'h0;
    active = 1'b0;
    w = 0;
    stray_done = 0;
    cap = '0;
    forever begin
      @(negedge clk);
      if (bus.dbg_mem_ack) begin
        bus.dbg_mem_ack = 1'b0;
        active = 1'b0;
      end else if (stray_req != stray_done) begin
        bus.dbg_mem_ack = 1'b1;
        bus.dbg_di = 32'hDEADBEEF;
        stray_done = stray_req;
      end else if (bus.dbg_mem_op && !ack_hold) begin
        if (!active) begin
          active = 1'b1;
          cap = '{bus.dbg_adr, bus.dbg_do, bus.dbg_wren};
          w = 0;
        end else if (cap !== mem_t'({bus.dbg_adr, bus.dbg_do, bus.dbg_wren})) begin
          unstable++;
        end
        if (w >= mem_lat) begin
          bus.dbg_mem_ack = 1'b1;
          bus.dbg_di = rd_word;
          obs_mem.push_back(cap);
        end else begin
          w++;
        end
      end else if (!bus.dbg_mem_op) begin
        active = 1'b0;
      end
    end
  end

  // Transmitter model: busy for tx_len cycles after each start pulse.
  initial begin : tx_mon
    int bc;
    bus.tx_busy = 1'b0;
    bc = 0;
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) begin
        if (bus.tx_busy) tx_viol++;
        obs_tx.push_back(bus.tx_data);
        bus.tx_busy = 1'b1;
        bc = tx_len;
      end else if (bus.tx_busy) begin
        if (bc == 0) bus.tx_busy = 1'b0;
        else bc--;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] cmd, input logic [31:0] w);
    send_byte(cmd);
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    n_reset = 1'b0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    exp_mem.delete(); obs_mem.delete(); exp_tx.delete(); obs_tx.delete();
  endtask

  task automatic push_read(input logic [31:0] adr, input logic [31:0] w);
    exp_mem.push_back('{adr, 32'h0, 4'h0});
    for (int i = 0; i < 4; i++) exp_tx.push_back(w[i*8 +: 8]);
  endtask

  task automatic wait_done(input int limit, output bit ok);
    int c;
    c = 0;
    while ((obs_mem.size() < exp_mem.size() || obs_tx.size() < exp_tx.size()) && c < limit) begin
      @(negedge clk);
      c++;
    end
    ok = (obs_mem.size() >= exp_mem.size() && obs_tx.size() >= exp_tx.size());
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [78:0] got;
    repeat (2) @(negedge clk);
    got = {bus.tx_start, bus.tx_data, bus.dbg_mem_op, bus.dbg_wren, bus.dbg_adr, bus.dbg_do, bus.cpu_n_reset};
    n_cmp++;
    if (got !== {1'b0, 8'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1}) begin
      n_err++; $display("FAIL reset_in: got %h want %h", got, {1'b0, 8'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1});
    end
    n_reset = 1'b1;
    repeat (3) @(negedge clk);
    got = {bus.tx_start, bus.tx_data, bus.dbg_mem_op, bus.dbg_wren, bus.dbg_adr, bus.dbg_do, bus.cpu_n_reset};
    n_cmp++;
    if (got !== {1'b0, 8'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1}) begin
      n_err++; $display("FAIL reset_out: got %h want %h", got, {1'b0, 8'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1});
    end
  endtask

  task automatic test_write();
    bit ok;
    mem_t m, e;
    apply_reset();
    mem_lat = 2;
    send_word(8'h01, 32'h0000_0020);
    exp_mem.push_back('{32'h0000_0020, 32'hAABB_CCDD, 4'hF});
    send_word(8'h04, 32'hAABB_CCDD);
    wait_done(200, ok);
    n_cmp++;
    if (!ok || obs_mem.size() != exp_mem.size()) begin
      n_err++; $display("FAIL write_count: got %0d ops want %0d", obs_mem.size(), exp_mem.size());
    end
    while (obs_mem.size() > 0 && exp_mem.size() > 0) begin
      m = obs_mem.pop_front(); e = exp_mem.pop_front(); n_cmp++;
      if (m !== e) begin
        n_err++; $display("FAIL write_mem: got adr=%h do=%h wren=%h want adr=%h do=%h wren=%h", m.adr, m.dat, m.wren, e.adr, e.dat, e.wren);
      end
    end
    n_cmp++;
    if (bus.dbg_adr !== 32'h0000_0024) begin
      n_err++; $display("FAIL write_ptr: got %h want %h", bus.dbg_adr, 32'h0000_0024);
    end
    n_cmp++;
    if (unstable !== 0) begin
      n_err++; $display("FAIL write_stable: got %0d unstable cycles want 0", unstable);
    end
  endtask

  task automatic test_read();
    bit ok;
    mem_t m, e;
    logic [7:0] b, eb;
    apply_reset();
    mem_lat = 2;
    tx_len = 8;
    rd_word = 32'hAABB_CCDD;
    send_word(8'h01, 32'h0000_0020);
    push_read(32'h0000_0020, 32'hAABB_CCDD);
    send_byte(8'h05);
    repeat (10) @(negedge clk);
    send_byte(8'h02);
    wait_done(300, ok);
    n_cmp++;
    if (!ok || obs_mem.size() != exp_mem.size() || obs_tx.size() != exp_tx.size()) begin
      n_err++; $display("FAIL read_count: got mem=%0d tx=%0d want mem=%0d tx=%0d", obs_mem.size(), obs_tx.size(), exp_mem.size(), exp_tx.size());
    end
    while (obs_mem.size() > 0 && exp_mem.size() > 0) begin
      m = obs_mem.pop_front(); e = exp_mem.pop_front(); n_cmp++;
      if (m.adr !== e.adr || m.wren !== e.wren) begin
        n_err++; $display("FAIL read_mem: got adr=%h wren=%h want adr=%h wren=%h", m.adr, m.wren, e.adr, e.wren);
      end
    end
    while (obs_tx.size() > 0 && exp_tx.size() > 0) begin
      b = obs_tx.pop_front(); eb = exp_tx.pop_front(); n_cmp++;
      if (b !== eb) begin
        n_err++; $display("FAIL read_tx: got %h want %h", b, eb);
      end
    end
    n_cmp++;
    if (tx_viol !== 0) begin
      n_err++; $display("FAIL read_busy: got %0d starts while busy want 0", tx_viol);
    end
    n_cmp++;
    if (bus.cpu_n_reset !== 1'b1 || bus.dbg_adr !== 32'h0000_0024) begin
      n_err++; $display("FAIL read_drop: got cpu_n_reset=%b ptr=%h want 1 %h", bus.cpu_n_reset, bus.dbg_adr, 32'h0000_0024);
    end
    tx_len = 3;
  endtask

  task automatic test_timeout();
    bit ok;
    mem_t m, e;
    logic [7:0] b, eb;
    apply_reset();
    mem_lat = 1;
    rd_word = 32'h1122_3344;
    send_byte(8'h01); send_byte(8'h20); send_byte(8'h00);
    repeat (TMO + 1) @(negedge clk);
    push_read(32'h0000_0000, 32'h1122_3344);
    send_byte(8'h05);
    wait_done(300, ok);
    send_byte(8'h01); send_byte(8'h10); send_byte(8'h00);
    repeat (TMO - 4) @(negedge clk);
    send_byte(8'h00); send_byte(8'h00);
    rd_word = 32'h5566_7788;
    push_read(32'h0000_0010, 32'h5566_7788);
    send_byte(8'h05);
    wait_done(300, ok);
    n_cmp++;
    if (!ok || obs_mem.size() != exp_mem.size() || obs_tx.size() != exp_tx.size()) begin
      n_err++; $display("FAIL timeout_count: got mem=%0d tx=%0d want mem=%0d tx=%0d", obs_mem.size(), obs_tx.size(), exp_mem.size(), exp_tx.size());
    end
    while (obs_mem.size() > 0 && exp_mem.size() > 0) begin
      m = obs_mem.pop_front(); e = exp_mem.pop_front(); n_cmp++;
      if (m.adr !== e.adr || m.wren !== e.wren) begin
        n_err++; $display("FAIL timeout_mem: got adr=%h wren=%h want adr=%h wren=%h", m.adr, m.wren, e.adr, e.wren);
      end
    end
    while (obs_tx.size() > 0 && exp_tx.size() > 0) begin
      b = obs_tx.pop_front(); eb = exp_tx.pop_front(); n_cmp++;
      if (b !== eb) begin
        n_err++; $display("FAIL timeout_tx: got %h want %h", b, eb);
      end
    end
  endtask

  task automatic test_halt();
    bit ok;
    mem_t m, e;
    apply_reset();
    send_byte(8'h02);
    n_cmp++;
    if (bus.cpu_n_reset !== 1'b0) begin
      n_err++; $display("FAIL halt: got cpu_n_reset=%b want 0", bus.cpu_n_reset);
    end
    exp_mem.push_back('{32'h0000_0000, 32'h4433_2211, 4'hF});
    send_word(8'h04, 32'h4433_2211);
    wait_done(200, ok);
    n_cmp++;
    if (!ok || obs_mem.size() != exp_mem.size() || bus.cpu_n_reset !== 1'b0) begin
      n_err++; $display("FAIL halt_write_count: got %0d ops cpu_n_reset=%b want %0d ops 0", obs_mem.size(), bus.cpu_n_reset, exp_mem.size());
    end
    while (obs_mem.size() > 0 && exp_mem.size() > 0) begin
      m = obs_mem.pop_front(); e = exp_mem.pop_front(); n_cmp++;
      if (m !== e) begin
        n_err++; $display("FAIL halt_mem: got adr=%h do=%h wren=%h want adr=%h do=%h wren=%h", m.adr, m.dat, m.wren, e.adr, e.dat, e.wren);
      end
    end
    send_byte(8'h03);
    n_cmp++;
    if (bus.cpu_n_reset !== 1'b1 || bus.dbg_adr !== 32'h0000_0004) begin
      n_err++; $display("FAIL run: got cpu_n_reset=%b ptr=%h want 1 %h", bus.cpu_n_reset, bus.dbg_adr, 32'h0000_0004);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    mem_t m, e;
    apply_reset();
    send_word(8'h01, 32'hFFFF_FFFC);
    exp_mem.push_back('{32'hFFFF_FFFC, 32'h0403_0201, 4'hF});
    send_word(8'h04, 32'h0403_0201);
    wait_done(200, ok);
    exp_mem.push_back('{32'h0000_0000, 32'h0807_0605, 4'hF});
    send_word(8'h04, 32'h0807_0605);
    wait_done(200, ok);
    send_byte(8'h7E);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (!ok || obs_mem.size() != exp_mem.size() || obs_tx.size() != 0) begin
      n_err++; $display("FAIL wrap_count: got mem=%0d tx=%0d want mem=%0d tx=0", obs_mem.size(), obs_tx.size(), exp_mem.size());
    end
    while (obs_mem.size() > 0 && exp_mem.size() > 0) begin
      m = obs_mem.pop_front(); e = exp_mem.pop_front(); n_cmp++;
      if (m !== e) begin
        n_err++; $display("FAIL wrap_mem: got adr=%h do=%h wren=%h want adr=%h do=%h wren=%h", m.adr, m.dat, m.wren, e.adr, e.dat, e.wren);
      end
    end
    n_cmp++;
    if (bus.dbg_adr !== 32'h0000_0004 || bus.dbg_mem_op !== 1'b0) begin
      n_err++; $display("FAIL unknown_cmd: got ptr=%h mem_op=%b want %h 0", bus.dbg_adr, bus.dbg_mem_op, 32'h0000_0004);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    mem_t m, e;
    logic [7:0] b, eb;
    apply_reset();
    mem_lat = 0;
    stray_req++;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (bus.dbg_adr !== 32'h0 || bus.dbg_mem_op !== 1'b0 || bus.tx_busy !== 1'b0) begin
      n_err++; $display("FAIL stray_ack: got ptr=%h mem_op=%b want 0 0", bus.dbg_adr, bus.dbg_mem_op);
    end
    rd_word = 32'hCAFE_F00D;
    send_word(8'h01, 32'h0000_0010);
    exp_mem.push_back('{32'h0000_0010, 32'h1234_5678, 4'hF});
    send_word(8'h04, 32'h1234_5678);
    push_read(32'h0000_0014, 32'hCAFE_F00D);
    send_byte(8'h05);
    wait_done(300, ok);
    n_cmp++;
    if (!ok || obs_mem.size() != exp_mem.size() || obs_tx.size() != exp_tx.size()) begin
      n_err++; $display("FAIL b2b_count: got mem=%0d tx=%0d want mem=%0d tx=%0d", obs_mem.size(), obs_tx.size(), exp_mem.size(), exp_tx.size());
    end
    while (obs_mem.size() > 0 && exp_mem.size() > 0) begin
      m = obs_mem.pop_front(); e = exp_mem.pop_front(); n_cmp++;
      if (m.adr !== e.adr || m.wren !== e.wren || (e.wren != 4'h0 && m.dat !== e.dat)) begin
        n_err++; $display("FAIL b2b_mem: got adr=%h do=%h wren=%h want adr=%h do=%h wren=%h", m.adr, m.dat, m.wren, e.adr, e.dat, e.wren);
      end
    end
    while (obs_tx.size() > 0 && exp_tx.size() > 0) begin
      b = obs_tx.pop_front(); eb = exp_tx.pop_front(); n_cmp++;
      if (b !== eb) begin
        n_err++; $display("FAIL b2b_tx: got %h want %h", b, eb);
      end
    end
    n_cmp++;
    if (bus.dbg_adr !== 32'h0000_0018 || unstable !== 0 || tx_viol !== 0) begin
      n_err++; $display("FAIL b2b_ptr: got ptr=%h unstable=%0d viol=%0d want %h 0 0", bus.dbg_adr, unstable, tx_viol, 32'h0000_0018);
    end
    mem_lat = 1;
  endtask

  task automatic test_reset_midop();
    bit ok;
    int c;
    mem_t m, e;
    logic [7:0] b, eb;
    apply_reset();
    ack_hold = 1'b1;
    send_word(8'h01, 32'h0000_0040);
    send_word(8'h04, 32'h0102_0304);
    c = 0;
    while (bus.dbg_mem_op !== 1'b1 && c < 10) begin @(negedge clk); c++; end
    n_cmp++;
    if (bus.dbg_mem_op !== 1'b1 || bus.dbg_adr !== 32'h0000_0040) begin
      n_err++; $display("FAIL midop_held: got mem_op=%b adr=%h want 1 %h", bus.dbg_mem_op, bus.dbg_adr, 32'h0000_0040);
    end
    #2 n_reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.dbg_mem_op !== 1'b0 || bus.dbg_adr !== 32'h0 || bus.dbg_wren !== 4'h0) begin
      n_err++; $display("FAIL midop_reset: got mem_op=%b adr=%h wren=%h want 0 0 0", bus.dbg_mem_op, bus.dbg_adr, bus.dbg_wren);
    end
    @(negedge clk);
    n_reset = 1'b1;
    ack_hold = 1'b0;
    rd_word = 32'h0BAD_F00D;
    push_read(32'h0000_0000, 32'h0BAD_F00D);
    send_byte(8'h05);
    wait_done(300, ok);
    n_cmp++;
    if (!ok || obs_mem.size() != exp_mem.size() || obs_tx.size() != exp_tx.size()) begin
      n_err++; $display("FAIL midop_count: got mem=%0d tx=%0d want mem=%0d tx=%0d", obs_mem.size(), obs_tx.size(), exp_mem.size(), exp_tx.size());
    end
    while (obs_mem.size() > 0 && exp_mem.size() > 0) begin
      m = obs_mem.pop_front(); e = exp_mem.pop_front(); n_cmp++;
      if (m.adr !== e.adr || m.wren !== e.wren) begin
        n_err++; $display("FAIL midop_mem: got adr=%h wren=%h want adr=%h wren=%h", m.adr, m.wren, e.adr, e.wren);
      end
    end
    while (obs_tx.size() > 0 && exp_tx.size() > 0) begin
      b = obs_tx.pop_front(); eb = exp_tx.pop_front(); n_cmp++;
      if (b !== eb) begin
        n_err++; $display("FAIL midop_tx: got %h want %h", b, eb);
      end
    end
  endtask

  initial begin : main
    n_reset = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_halt();
    test_wrap();
    test_back_to_back();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
